// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 binary multiplier (decode/normalise, mantissa product,
// round/encode) with a valid/ready handshake, RNE or truncation, and per-result IEEE flags.

module fp_mul_pipe #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10,
  localparam int unsigned W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] opA_i,
  input  logic [W-1:0] opB_i,
  input  logic         rnd_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] res_o,
  output logic [3:0]   flags_o
);

  localparam int ES         = EXP_W + 3;
  localparam int PW         = 2 * MAN_W + 2;
  localparam int XW         = PW + MAN_W + 3;
  localparam int BIAS       = (1 << (EXP_W - 1)) - 1;
  localparam int EMIN       = 1 - BIAS;
  localparam int EMAX_FIELD = (1 << EXP_W) - 1;
  localparam int SH_MAX     = MAN_W + 3;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Pipeline control
  logic v1_q, v2_q, v3_q;
  logic adv1, adv2, adv3;

  assign adv3        = ~v3_q | out_ready_i;
  assign adv2        = ~v2_q | adv3;
  assign adv1        = ~v1_q | adv2;
  assign in_ready_o  = adv1;
  assign out_valid_o = v3_q;

  // Stage 1: classify, normalise subnormals, add exponents
  function automatic int lead_shift(input logic [MAN_W-1:0] fr);
    int sh;
    sh = int'(MAN_W);
    for (int i = 0; i < int'(MAN_W); i++) begin
      if (fr[i]) sh = int'(MAN_W) - i;
    end
    return sh;
  endfunction

  function automatic logic [MAN_W:0] dec_mant(input logic [EXP_W-1:0] ex,
                                                input logic [MAN_W-1:0] fr);
    if (ex != '0) return {1'b1, fr};
    return {1'b0, fr} << lead_shift(fr);
  endfunction

  function automatic logic signed [ES-1:0] dec_exp(input logic [EXP_W-1:0] ex,
                                                    input logic [MAN_W-1:0] fr);
    if (ex != '0) return ES'(int'(ex) - BIAS);
    return ES'(EMIN - lead_shift(fr));
  endfunction

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             sign_d;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic             sp_d;
  logic [W-1:0]     sp_res_d;
  logic [3:0]       sp_flags_d;

  assign ea     = opA_i[W-2 -: EXP_W];
  assign eb     = opB_i[W-2 -: EXP_W];
  assign fa     = opA_i[MAN_W-1:0];
  assign fb     = opB_i[MAN_W-1:0];
  assign sign_d = opA_i[W-1] ^ opB_i[W-1];
  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_zero = ~(|ea) & ~(|fa);
  assign b_zero = ~(|eb) & ~(|fb);

  always_comb begin
    sp_d       = 1'b1;
    sp_res_d   = QNAN;
    sp_flags_d = 4'b0000;
    if (a_nan | b_nan) begin
      // Only a signalling NaN (quiet bit clear) raises invalid
      sp_flags_d = {(a_nan & ~fa[MAN_W-1]) | (b_nan & ~fb[MAN_W-1]), 3'b000};
    end else if ((a_inf & b_zero) | (b_inf & a_zero)) begin
      sp_flags_d = 4'b1000;
    end else if (a_inf | b_inf) begin
      sp_res_d = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero | b_zero) begin
      sp_res_d = {sign_d, {(W-1){1'b0}}};
    end else begin
      sp_d = 1'b0;
    end
  end

  logic                    s1_sign, s1_rnd, s1_sp;
  logic signed [ES-1:0]    s1_e;
  logic [MAN_W:0]          s1_ma, s1_mb;
  logic [W-1:0]            s1_sp_res;
  logic [3:0]              s1_sp_flags;

  // Stage 2: mantissa product, normalised so the leading one sits at the top bit
  logic [PW-1:0]           prod;
  logic [PW-1:0]           s2_p_d;
  logic signed [ES-1:0]    s2_e_d;

  always_comb begin
    prod   = PW'(s1_ma) * PW'(s1_mb);
    s2_p_d = prod[PW-1] ? prod : (prod << 1);
    s2_e_d = prod[PW-1] ? (s1_e + ES'(1)) : s1_e;
  end

  logic                    s2_sign, s2_rnd, s2_sp;
  logic signed [ES-1:0]    s2_e;
  logic [PW-1:0]           s2_p;
  logic [W-1:0]            s2_sp_res;
  logic [3:0]              s2_sp_flags;

  // Stage 3: denormalising shift, rounding, overflow and encoding
  int               e_i, d, biased;
  logic             tiny, guard, sticky, inc, inexact;
  logic [XW-1:0]    ext;
  logic [MAN_W:0]   mant;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] frac;
  logic [W-1:0]     res_d;
  logic [3:0]       flags_d;

  always_comb begin
    e_i    = int'(s2_e);
    tiny   = e_i < EMIN;
    d      = 0;
    if (tiny) d = ((EMIN - e_i) > SH_MAX) ? SH_MAX : (EMIN - e_i);
    ext     = {s2_p, {(MAN_W+3){1'b0}}} >> d;
    mant    = ext[XW-1 -: MAN_W+1];
    guard   = ext[XW-MAN_W-2];
    sticky  = |ext[XW-MAN_W-3:0];
    inc     = s2_rnd & guard & (sticky | mant[0]);
    inexact = guard | sticky;
    mant_r  = {1'b0, mant} + {{(MAN_W+1){1'b0}}, inc};
    biased  = tiny ? 0 : (e_i + BIAS);
    frac    = mant_r[MAN_W-1:0];
    if (mant_r[MAN_W+1]) begin
      biased = biased + 1;
      frac   = mant_r[MAN_W:1];
    end else if (tiny) begin
      // A subnormal that rounds up into the hidden bit becomes the smallest normal
      biased = mant_r[MAN_W] ? 1 : 0;
    end
    res_d   = {s2_sign, EXP_W'(biased), frac};
    flags_d = {2'b00, tiny & inexact, inexact};
    if (!tiny && biased >= EMAX_FIELD) begin
      res_d   = s2_rnd ? {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                       : {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      flags_d = 4'b0101;
    end
    if (s2_sp) begin
      res_d   = s2_sp_res;
      flags_d = s2_sp_flags;
    end
  end

  logic [W-1:0] res_q;
  logic [3:0]   flags_q;

  assign res_o   = res_q;
  assign flags_o = flags_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      s1_sign     <= 1'b0;
      s1_rnd      <= 1'b0;
      s1_sp       <= 1'b0;
      s1_e        <= '0;
      s1_ma       <= '0;
      s1_mb       <= '0;
      s1_sp_res   <= '0;
      s1_sp_flags <= '0;
      s2_sign     <= 1'b0;
      s2_rnd      <= 1'b0;
      s2_sp       <= 1'b0;
      s2_e        <= '0;
      s2_p        <= '0;
      s2_sp_res   <= '0;
      s2_sp_flags <= '0;
      res_q       <= '0;
      flags_q     <= '0;
    end else begin
      if (adv1) begin
        v1_q        <= in_valid_i;
        s1_sign     <= sign_d;
        s1_rnd      <= rnd_i;
        s1_sp       <= sp_d;
        s1_e        <= dec_exp(ea, fa) + dec_exp(eb, fb);
        s1_ma       <= dec_mant(ea, fa);
        s1_mb       <= dec_mant(eb, fb);
        s1_sp_res   <= sp_res_d;
        s1_sp_flags <= sp_flags_d;
      end
      if (adv2) begin
        v2_q        <= v1_q;
        s2_sign     <= s1_sign;
        s2_rnd      <= s1_rnd;
        s2_sp       <= s1_sp;
        s2_e        <= s2_e_d;
        s2_p        <= s2_p_d;
        s2_sp_res   <= s1_sp_res;
        s2_sp_flags <= s1_sp_flags;
      end
      if (adv3) begin
        v3_q    <= v2_q;
        res_q   <= res_d;
        flags_q <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: directed FP16 vectors, backpressure, random traffic against an
// exact integer-arithmetic reference model, async reset flush, and one FP32 vector.

module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, rnd, out_valid, out_ready;
  logic [15:0] op_a, op_b, res;
  logic [3:0]  flags;

  logic        in_valid32, in_ready32, rnd32, out_valid32, out_ready32;
  logic [31:0] a32, b32, res32;
  logic [3:0]  flags32;

  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .opA_i       (op_a),
    .opB_i       (op_b),
    .rnd_i       (rnd),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .res_o       (res),
    .flags_o     (flags)
  );

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid32),
    .in_ready_o  (in_ready32),
    .opA_i       (a32),
    .opB_i       (b32),
    .rnd_i       (rnd32),
    .out_valid_o (out_valid32),
    .out_ready_i (out_ready32),
    .res_o       (res32),
    .flags_o     (flags32)
  );

  int          checks = 0;
  int          errors = 0;
  int          accepted = 0;
  logic [19:0] sb_q[$];  // {flags, result} in issue order

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Reference: exact product P*2^et, then quantise to the FP16 grid of the result binade.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic r);
    logic s;
    logic [4:0] ea, eb;
    logic [9:0] fa, fb;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, tiny, inex;
    longint unsigned ma, mb, p, rr, rem, half;
    int ex_a, ex_b, et, k, vexp, re, sh;
    logic [15:0] rs;
    s  = a[15] ^ b[15];
    ea = a[14:10]; eb = b[14:10];
    fa = a[9:0];   fb = b[9:0];
    a_nan  = (ea == 5'h1f) && (fa != 0);
    b_nan  = (eb == 5'h1f) && (fb != 0);
    a_inf  = (ea == 5'h1f) && (fa == 0);
    b_inf  = (eb == 5'h1f) && (fb == 0);
    a_zero = (ea == 0) && (fa == 0);
    b_zero = (eb == 0) && (fb == 0);
    if (a_nan || b_nan) begin
      if ((a_nan && !fa[9]) || (b_nan && !fb[9])) return {4'b1000, 16'h7E00};
      return {4'b0000, 16'h7E00};
    end
    if ((a_inf && b_zero) || (b_inf && a_zero)) return {4'b1000, 16'h7E00};
    if (a_inf || b_inf) return {4'b0000, s, 15'h7C00};
    if (a_zero || b_zero) return {4'b0000, s, 15'h0000};
    ma   = (ea == 0) ? 64'(fa) : 64'(fa) + 64'd1024;
    mb   = (eb == 0) ? 64'(fb) : 64'(fb) + 64'd1024;
    ex_a = (ea == 0) ? -24 : int'(ea) - 25;
    ex_b = (eb == 0) ? -24 : int'(eb) - 25;
    p    = ma * mb;
    et   = ex_a + ex_b;
    k    = 0;
    for (int i = 0; i < 22; i++) if (p[i]) k = i;
    vexp = k + et;
    tiny = vexp < -14;
    re   = tiny ? -14 : vexp;
    sh   = re - 10 - et;
    if (sh <= 0) begin
      rr = p << (-sh); rem = 0; half = 0;
    end else begin
      rr = p >> sh; rem = p & ((64'd1 << sh) - 1); half = 64'd1 << (sh - 1);
    end
    inex = rem != 0;
    if (r && sh > 0 && (rem > half || (rem == half && rr[0]))) rr = rr + 1;
    if (rr == 2048) begin rr = 1024; re = re + 1; end
    if (re > 15) return r ? {4'b0101, s, 15'h7C00} : {4'b0101, s, 15'h7BFF};
    if (rr >= 1024) rs = {s, 5'(re + 15), 10'(rr - 1024)};
    else            rs = {s, 5'd0, 10'(rr)};
    return {2'b00, tiny && inex, inex, rs};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [4:0] e;
    logic [9:0] f;
    f = 10'($urandom);
    case ($urandom_range(0, 9))
      0: begin e = 5'd0;  if ($urandom_range(0, 1) == 0) f = 10'd0; end
      1: begin e = 5'h1f; if ($urandom_range(0, 1) == 0) f = 10'd0; end
      2: e = 5'($urandom_range(1, 6));
      3: e = 5'($urandom_range(24, 30));
      default: e = 5'($urandom_range(1, 30));
    endcase
    return {1'($urandom), e, f};
  endfunction

  // One clock: drive at negedge, then check the output head and record an accepted input.
  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic r, input logic ordy);
    @(negedge clk);
    in_valid = v; op_a = a; op_b = b; rnd = r; out_ready = ordy;
    #1;
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        chk("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("res", 32'(res), 32'(sb_q[0][15:0]));
        chk("flags", 32'(flags), 32'(sb_q[0][19:16]));
        if (out_ready) void'(sb_q.pop_front());
      end
    end
    if (v && in_ready) begin
      sb_q.push_back(model(a, b, r));
      accepted++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic r, input logic [15:0] want_res, input logic [3:0] want_fl,
                         input int want_lat);
    int lat;
    step(1'b1, a, b, r, 1'b1);
    lat = 0;
    do begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      lat++;
    end while (!out_valid && lat < 10);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_res"}, 32'(res), 32'(want_res));
    chk({tag, "_flags"}, 32'(flags), 32'(want_fl));
    if (want_lat > 0) chk({tag, "_latency"}, 32'(lat), 32'(want_lat));
  endtask

  initial begin
    logic [15:0] bp_a[6], bp_b[6];
    logic [15:0] pa, pb;
    logic        pr, pend, got;
    int          idx, acc0, stale;

    rst = 1'b1;
    in_valid = 1'b0; op_a = '0; op_b = '0; rnd = 1'b0; out_ready = 1'b0;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; rnd32 = 1'b0; out_ready32 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_res", 32'(res), 32'd0);
    chk("reset_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    run_vec("one_x_1p5", 16'h3C00, 16'h3E00, 1'b1, 16'h3E00, 4'b0000, 3);
    run_vec("ovf_rne", 16'h7BFF, 16'h4000, 1'b1, 16'h7C00, 4'b0101, 3);
    run_vec("ovf_rtz", 16'h7BFF, 16'h4000, 1'b0, 16'h7BFF, 4'b0101, 0);
    run_vec("sub_tie", 16'h0001, 16'h3800, 1'b1, 16'h0000, 4'b0011, 0);
    run_vec("sub_up", 16'h0001, 16'h3A00, 1'b1, 16'h0001, 4'b0011, 0);
    run_vec("sub_exact", 16'h0400, 16'h3800, 1'b1, 16'h0200, 4'b0000, 0);
    run_vec("inf_x_zero", 16'h7C00, 16'h8000, 1'b1, 16'h7E00, 4'b1000, 0);
    run_vec("snan", 16'h7D00, 16'h3C00, 1'b1, 16'h7E00, 4'b1000, 0);
    run_vec("neg_inf", 16'hFC00, 16'h4000, 1'b1, 16'hFC00, 4'b0000, 0);

    // Backpressure: six back-to-back ops with the output stalled for five cycles
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = rand_op();
      bp_b[i] = rand_op();
    end
    idx  = 0;
    acc0 = accepted;
    for (int i = 0; i < 5; i++) begin
      pend = (accepted != acc0 + idx);
      step(1'b1, bp_a[idx], bp_b[idx], 1'b1, 1'b0);
      if (accepted != acc0 + idx) idx++;
    end
    chk("bp_accepted", 32'(accepted - acc0), 32'd3);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 50 && idx < 6; i++) begin
      step(1'b1, bp_a[idx], bp_b[idx], 1'b1, 1'b1);
      if (accepted != acc0 + idx) idx++;
    end
    chk("bp_all_issued", 32'(idx), 32'd6);
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("bp_drained", 32'(sb_q.size()), 32'd0);

    // Random traffic with random ready toggling
    pend = 1'b0; pa = '0; pb = '0; pr = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!pend) begin
        pa = rand_op();
        pb = rand_op();
        pr = 1'($urandom);
      end
      acc0 = accepted;
      step($urandom_range(0, 3) != 0, pa, pb, pr, $urandom_range(0, 9) < 7);
      pend = (accepted == acc0);
    end
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("rand_drained", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset with two items in flight
    step(1'b1, 16'h3C00, 16'h4000, 1'b1, 1'b0);
    step(1'b1, 16'h4000, 16'h4000, 1'b1, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_valid", 32'(out_valid), 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      if (out_valid) stale++;
    end
    chk("post_reset_stale", 32'(stale), 32'd0);
    chk("post_reset_ready", 32'(in_ready), 32'd1);
    run_vec("after_reset", 16'h3C00, 16'h3E00, 1'b1, 16'h3E00, 4'b0000, 3);

    // FP32 instance
    @(negedge clk);
    in_valid32 = 1'b1; a32 = 32'h3F800000; b32 = 32'h40000000; rnd32 = 1'b1;
    out_ready32 = 1'b1;
    #1;
    chk("fp32_in_ready", 32'(in_ready32), 32'd1);
    @(negedge clk);
    in_valid32 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if (out_valid32) got = 1'b1;
      else @(negedge clk);
    end
    chk("fp32_valid", 32'(got), 32'd1);
    chk("fp32_res", res32, 32'h40000000);
    chk("fp32_flags", 32'(flags32), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
